// File: rtl/mem_store_buffer.sv
// mem_store_buffer: FIFO store buffer between the MEM stage and DataMemory; define STORE_FWD_EN to forward load hits from buffered stores
module mem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          CpuWrite,
    input  logic          CpuRead,
    input  logic [AW-1:0] CpuAdresa,
    input  logic [DW-1:0] CpuWriteData,
    output logic [DW-1:0] CpuReadData,
    output logic          Stall,
    output logic          Empty,
    output logic [AW-1:0] MemAdresa,
    output logic [DW-1:0] MemWriteData,
    output logic          MemWrite,
    output logic          MemRead,
    input  logic [DW-1:0] MemReadData
);
    localparam int PW = $clog2(DEPTH);
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0]   count;
    logic          full, hit, drain, enq;
`ifdef STORE_FWD_EN
    logic [DW-1:0] hit_data;
`endif
    assign full  = count == (PW+1)'(DEPTH);
    assign Empty = count == '0;
    // Scan valid entries oldest to youngest so the youngest match is the one kept
    always_comb begin
        hit = 1'b0;
`ifdef STORE_FWD_EN
        hit_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count) && addr_q[head + PW'(i)] == CpuAdresa) begin
                hit = 1'b1;
`ifdef STORE_FWD_EN
                hit_data = data_q[head + PW'(i)];
`endif
            end
        end
    end
    // Arbitrate the single memory port between loads, stores and drains
    always_comb begin
        Stall        = 1'b0;
        MemRead      = 1'b0;
        drain        = 1'b0;
        enq          = 1'b0;
        CpuReadData  = '0;
        MemAdresa    = addr_q[head];
        MemWriteData = data_q[head];
        if (CpuRead) begin
            Stall = CpuWrite;
            if (hit) begin
`ifdef STORE_FWD_EN
                MemAdresa   = CpuAdresa;
                CpuReadData = hit_data;
`else
                Stall = 1'b1;
                drain = 1'b1;
`endif
            end else begin
                MemRead     = 1'b1;
                MemAdresa   = CpuAdresa;
                CpuReadData = MemReadData;
            end
        end else if (CpuWrite) begin
            Stall = full;
            drain = full;
            enq   = !full;
        end else begin
            drain = !Empty;
        end
        MemWrite = drain;
    end
    // Pointer and occupancy bookkeeping; enqueue and drain never coincide
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + PW'(1);
            if (drain) head <= head + PW'(1);
            if (enq) count <= count + (PW+1)'(1);
            else if (drain) count <= count - (PW+1)'(1);
        end
    end
    // Entry storage needs no reset; occupancy gates every use
    always_ff @(posedge Clock) begin
        if (enq) begin
            addr_q[tail] <= CpuAdresa;
            data_q[tail] <= CpuWriteData;
        end
    end
endmodule

// File: tb/tb_mem_store_buffer.sv
// tb_mem_store_buffer: directed vectors plus randomized traffic against a queue-based store buffer model
module tb_mem_store_buffer;
    localparam int DEPTH = 4;
    logic        Clock = 1'b0, Reset = 1'b1;
    logic        CpuWrite = 1'b0, CpuRead = 1'b0;
    logic [15:0] CpuAdresa = '0, CpuWriteData = '0;
    logic [15:0] CpuReadData, MemAdresa, MemWriteData, MemReadData;
    logic        Stall, Empty, MemWrite, MemRead;
    logic [15:0] mem [65536];
    logic [15:0] ref_mem [65536];
    int n_cmp = 0, n_bad = 0;

    typedef struct {
        logic rd, wr;
        logic [15:0] a, d;
        logic stall, mrd, mwr;
        logic [15:0] madr, mwd, crd;
        logic empty;
    } vec_t;
    typedef struct { logic [15:0] addr, data; } ent_t;
    vec_t tbl[$];
    ent_t sb[$];
    logic e_stall, e_mrd, e_mwr, e_empty, e_enq, e_chk_crd;
    logic [15:0] e_madr, e_mwd, e_crd, e_a, e_d;
    logic we_c;
    logic [15:0] wa_c, wd_c;

    mem_store_buffer #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
        .Clock(Clock), .Reset(Reset), .CpuWrite(CpuWrite), .CpuRead(CpuRead),
        .CpuAdresa(CpuAdresa), .CpuWriteData(CpuWriteData), .CpuReadData(CpuReadData),
        .Stall(Stall), .Empty(Empty), .MemAdresa(MemAdresa), .MemWriteData(MemWriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
    );

    always #5 Clock = ~Clock;
    assign MemReadData = mem[MemAdresa];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rd, wr, input logic [15:0] a, d,
                                input logic stall, mrd, mwr, input logic [15:0] madr, mwd, crd,
                                input logic empty);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.d = d;
        v.stall = stall; v.mrd = mrd; v.mwr = mwr;
        v.madr = madr; v.mwd = mwd; v.crd = crd; v.empty = empty;
        return v;
    endfunction

    // Reference: buffer is a queue, oldest at index 0; decisions follow the stated rules
    function automatic void ref_eval(input logic rd, wr, input logic [15:0] a, d);
        int n = sb.size();
        int h = -1;
        for (int i = n - 1; i >= 0; i--) begin
            if (sb[i].addr == a) begin
                h = i;
                break;
            end
        end
        e_stall = 0; e_mrd = 0; e_mwr = 0; e_enq = 0; e_chk_crd = 1;
        e_madr = '0; e_mwd = '0; e_crd = '0; e_a = a; e_d = d;
        if (rd) begin
            e_stall = wr;
            if (h >= 0) begin
`ifdef STORE_FWD_EN
                e_crd = sb[h].data;
`else
                e_stall = 1; e_mwr = 1; e_chk_crd = 0;
`endif
            end else begin
                e_mrd = 1; e_madr = a; e_crd = ref_mem[a];
            end
        end else if (wr) begin
            if (n == DEPTH) begin e_stall = 1; e_mwr = 1; end
            else e_enq = 1;
        end else if (n > 0) begin
            e_mwr = 1;
        end
        if (e_mwr) begin e_madr = sb[0].addr; e_mwd = sb[0].data; end
        e_empty = (n == 0);
    endfunction

    task automatic drive(input logic rd, wr, input logic [15:0] a, d);
        @(negedge Clock);
        CpuRead = rd; CpuWrite = wr; CpuAdresa = a; CpuWriteData = d;
        #1;
        ref_eval(rd, wr, a, d);
    endtask

    task automatic commit();
        we_c = MemWrite; wa_c = MemAdresa; wd_c = MemWriteData;
        @(posedge Clock);
        if (we_c) mem[wa_c] = wd_c;
        if (e_mwr) begin
            ref_mem[sb[0].addr] = sb[0].data;
            void'(sb.pop_front());
        end
        if (e_enq) sb.push_back('{e_a, e_d});
    endtask

    task automatic apply(input vec_t v, input int k);
        drive(v.rd, v.wr, v.a, v.d);
        chk($sformatf("v%0d stall", k), 32'(Stall), 32'(v.stall));
        chk($sformatf("v%0d memread", k), 32'(MemRead), 32'(v.mrd));
        chk($sformatf("v%0d memwrite", k), 32'(MemWrite), 32'(v.mwr));
        chk($sformatf("v%0d empty", k), 32'(Empty), 32'(v.empty));
        if (v.mrd || v.mwr) chk($sformatf("v%0d memadr", k), 32'(MemAdresa), 32'(v.madr));
        if (v.mwr) chk($sformatf("v%0d memwd", k), 32'(MemWriteData), 32'(v.mwd));
        if (!(v.stall && !v.mrd)) chk($sformatf("v%0d cpurd", k), 32'(CpuReadData), 32'(v.crd));
        commit();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 16'hC000 + 16'(i);
            ref_mem[i] = 16'hC000 + 16'(i);
        end
        // directed: single store/drain/load, full buffer, same-address stores, miss, protocol violation
        tbl.push_back(mk(0,1,16'h2,16'h69,   0,0,0,16'h0,16'h0,16'h0,1));
        tbl.push_back(mk(0,0,16'h0,16'h0,    0,0,1,16'h2,16'h69,16'h0,0));
        tbl.push_back(mk(1,0,16'h2,16'h0,    0,1,0,16'h2,16'h0,16'h69,1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,1,16'(i),16'hA0+16'(i), 0,0,0,16'h0,16'h0,16'h0,i == 0));
        tbl.push_back(mk(0,1,16'h4,16'hA4,   1,0,1,16'h0,16'hA0,16'h0,0));
        tbl.push_back(mk(0,1,16'h4,16'hA4,   0,0,0,16'h0,16'h0,16'h0,0));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(0,0,16'h0,16'h0, 0,0,1,16'(i),16'hA0+16'(i),16'h0,0));
        tbl.push_back(mk(0,0,16'h0,16'h0,    0,0,0,16'h0,16'h0,16'h0,1));
        tbl.push_back(mk(0,1,16'h8,16'h1111, 0,0,0,16'h0,16'h0,16'h0,1));
        tbl.push_back(mk(0,1,16'h8,16'h2222, 0,0,0,16'h0,16'h0,16'h0,0));
`ifdef STORE_FWD_EN
        tbl.push_back(mk(1,0,16'h8,16'h0,    0,0,0,16'h0,16'h0,16'h2222,0));
        tbl.push_back(mk(0,0,16'h0,16'h0,    0,0,1,16'h8,16'h1111,16'h0,0));
        tbl.push_back(mk(0,0,16'h0,16'h0,    0,0,1,16'h8,16'h2222,16'h0,0));
`else
        tbl.push_back(mk(1,0,16'h8,16'h0,    1,0,1,16'h8,16'h1111,16'h0,0));
        tbl.push_back(mk(1,0,16'h8,16'h0,    1,0,1,16'h8,16'h2222,16'h0,0));
        tbl.push_back(mk(1,0,16'h8,16'h0,    0,1,0,16'h8,16'h0,16'h2222,1));
`endif
        tbl.push_back(mk(0,0,16'h0,16'h0,    0,0,0,16'h0,16'h0,16'h0,1));
        tbl.push_back(mk(0,1,16'h10,16'h1,   0,0,0,16'h0,16'h0,16'h0,1));
        tbl.push_back(mk(0,1,16'h11,16'h2,   0,0,0,16'h0,16'h0,16'h0,0));
        tbl.push_back(mk(1,0,16'h20,16'h0,   0,1,0,16'h20,16'h0,16'hC020,0));
        tbl.push_back(mk(0,0,16'h0,16'h0,    0,0,1,16'h10,16'h1,16'h0,0));
        tbl.push_back(mk(0,0,16'h0,16'h0,    0,0,1,16'h11,16'h2,16'h0,0));
        tbl.push_back(mk(1,1,16'h5,16'h77,   1,1,0,16'h5,16'h0,16'hC005,1));
        tbl.push_back(mk(0,0,16'h0,16'h0,    0,0,0,16'h0,16'h0,16'h0,1));

        repeat (2) @(negedge Clock);
        #1;
        chk("reset empty", 32'(Empty), 32'd1);
        chk("reset memwrite", 32'(MemWrite), 32'd0);
        chk("reset stall", 32'(Stall), 32'd0);
        chk("reset cpurd", 32'(CpuReadData), 32'd0);
        Reset = 1'b0;
        foreach (tbl[k]) apply(tbl[k], k);

        // reset while stores are pending: they must be discarded
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 16'h30 + 16'(i), 16'hDEA0 + 16'(i));
            commit();
        end
        @(negedge Clock);
        CpuRead = 0; CpuWrite = 0; Reset = 1'b1;
        #1;
        chk("midreset empty", 32'(Empty), 32'd1);
        chk("midreset memwrite", 32'(MemWrite), 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        sb.delete();
        for (int i = 0; i < 3; i++)
            apply(mk(1,0,16'h30+16'(i),16'h0, 0,1,0,16'h30+16'(i),16'h0,16'hC030+16'(i),1), 100 + i);

        // randomized traffic over a small address window to provoke hits and full stalls
        for (int c = 0; c < 3000; c++) begin
            int r = $urandom_range(0, 9);
            logic [15:0] a = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
            drive(r >= 6, (r >= 3 && r <= 5) || r == 9, a, 16'($urandom));
            chk("rnd stall", 32'(Stall), 32'(e_stall));
            chk("rnd memread", 32'(MemRead), 32'(e_mrd));
            chk("rnd memwrite", 32'(MemWrite), 32'(e_mwr));
            chk("rnd empty", 32'(Empty), 32'(e_empty));
            if (e_mrd || e_mwr) chk("rnd memadr", 32'(MemAdresa), 32'(e_madr));
            if (e_mwr) chk("rnd memwd", 32'(MemWriteData), 32'(e_mwd));
            if (e_chk_crd) chk("rnd cpurd", 32'(CpuReadData), 32'(e_crd));
            commit();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
